tensor_core_operand_sequencer: RTL and testbench

//  Upstream feeder and result drain for small_tensor_core_mma. Takes a nibble stream (A then B,
//  row-major), packs both 4x4 operands, pulses the core's write enable, waits for
//  is_done_with_calculation and streams the 16 result elements back out row-major.

---
 rtl/tensor_core_pkg.sv | 22 ++
 rtl/nibble_matrix_packer.sv | 35 +++
 rtl/tensor_core_operand_sequencer.sv | 146 ++++++++++++++
 tb/tb_tensor_core_operand_sequencer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tensor_core_pkg.sv
// Shared types and packing helper for the tensor core operand sequencer.
package tensor_core_pkg;

    localparam int ELEM_W = 4;
    localparam int DIM    = 4;
    localparam int MAT_W  = DIM * DIM * ELEM_W;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        START,
        WAIT,
        DRAIN
    } seq_state_e;

    // Bit offset of element (row, col) in a packed 4x4 matrix of 4-bit elements.
    // ((3-row)*4 + (3-col))*4 reduces to {~row, ~col, 2'b00}: (0,0) -> 60, (3,3) -> 0.
    function automatic logic [5:0] elem_lsb(input logic [1:0] row, input logic [1:0] col);
        return {~row, ~col, 2'b00};
    endfunction

endpackage

// File: rtl/nibble_matrix_packer.sv
// Index-addressed nibble write into a packed 4x4 matrix register.
module nibble_matrix_packer
    import tensor_core_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [3:0]        wr_idx_i,
    input  logic [ELEM_W-1:0] wr_data_i,
    output logic [MAT_W-1:0]  mat_o
);

    logic [MAT_W-1:0] mat_q;
    logic [MAT_W-1:0] mat_d;

    // Overwrite only the addressed element; row-major index splits into row/col.
    always_comb begin
        mat_d = mat_q;
        if (wr_en_i) begin
            mat_d[elem_lsb(wr_idx_i[3:2], wr_idx_i[1:0]) +: ELEM_W] = wr_data_i;
        end
    end

    // Matrix register, cleared on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mat_q <= '0;
        end else begin
            mat_q <= mat_d;
        end
    end

    assign mat_o = mat_q;

endmodule

// File: rtl/tensor_core_operand_sequencer.sv
// Feeds packed A/B operands to the MMA core, kicks it, and streams the 16 results back out.
module tensor_core_operand_sequencer #(
    parameter int ELEM_W  = 4,
    parameter int DIM     = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                      clock_in,
    input  logic                      reset_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ELEM_W-1:0]         in_data,
    output logic [DIM*DIM*ELEM_W-1:0] tensor_core_input1,
    output logic [DIM*DIM*ELEM_W-1:0] tensor_core_input2,
    output logic                      tensor_core_register_file_write_enable,
    input  logic [DIM*DIM*ELEM_W-1:0] tensor_core_output,
    input  logic                      is_done_with_calculation,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ELEM_W-1:0]         out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      error
);
    import tensor_core_pkg::*;

    localparam int RES_W  = DIM * DIM * ELEM_W;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    seq_state_e        state_q, state_d;
    logic [4:0]        fill_q, fill_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [3:0]        drain_q, drain_d;
    logic [RES_W-1:0]  result_q, result_d;
    logic              error_q, error_d;
    logic              load_ready;
    logic              accept;

    // Input is refused while reset is held, so nothing is loaded during the reset cycle.
    assign in_ready = load_ready & ~reset_in;
    assign accept   = in_valid & in_ready;

    // Fill index bit 4 selects the B half of the stream; low bits are the row-major element.
    nibble_matrix_packer u_pack_a (
        .clk_i    (clock_in),
        .rst_i    (reset_in),
        .wr_en_i  (accept & ~fill_q[4]),
        .wr_idx_i (fill_q[3:0]),
        .wr_data_i(in_data),
        .mat_o    (tensor_core_input1)
    );

    nibble_matrix_packer u_pack_b (
        .clk_i    (clock_in),
        .rst_i    (reset_in),
        .wr_en_i  (accept & fill_q[4]),
        .wr_idx_i (fill_q[3:0]),
        .wr_data_i(in_data),
        .mat_o    (tensor_core_input2)
    );

    // Next-state and handshake outputs for the load / start / wait / drain sequence.
    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        wait_d     = wait_q;
        drain_d    = drain_q;
        result_d   = result_q;
        error_d    = error_q;
        load_ready = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        tensor_core_register_file_write_enable = 1'b0;

        case (state_q)
            LOAD_A, LOAD_B: begin
                load_ready = 1'b1;
                if (accept) begin
                    fill_d = fill_q + 5'd1;
                    if (fill_q == 5'd15) begin
                        state_d = LOAD_B;
                    end else if (fill_q == 5'd31) begin
                        state_d = START;
                    end
                end
            end
            START: begin
                busy    = 1'b1;
                tensor_core_register_file_write_enable = 1'b1;
                wait_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                busy   = 1'b1;
                wait_d = wait_q + 1'b1;
                // First WAIT cycle ignores done: the core only clears it on the START edge.
                if ((wait_q != '0) && is_done_with_calculation) begin
                    result_d = tensor_core_output;
                    drain_d  = 4'd0;
                    state_d  = DRAIN;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    fill_d  = 5'd0;
                    state_d = LOAD_A;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    drain_d = drain_q + 4'd1;
                    if (drain_q == 4'd15) begin
                        fill_d  = 5'd0;
                        state_d = LOAD_A;
                    end
                end
            end
            default: begin
                state_d = LOAD_A;
            end
        endcase
    end

    // State, counters, captured result and sticky error.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q  <= LOAD_A;
            fill_q   <= '0;
            wait_q   <= '0;
            drain_q  <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            wait_q   <= wait_d;
            drain_q  <= drain_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    assign out_data = result_q[elem_lsb(drain_q[3:2], drain_q[1:0]) +: ELEM_W];
    assign out_last = (state_q == DRAIN) && (drain_q == 4'd15);
    assign error    = error_q;

endmodule

// File: tb/tb_tensor_core_operand_sequencer.sv
module tb_tensor_core_operand_sequencer;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic [63:0] a_pk;
    logic [63:0] b_pk;
    logic        we;
    logic [63:0] c_pk = '0;
    logic        done = 1'b0;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        error;

    int vectors = 0;
    int errors  = 0;

    // Core model state
    logic [63:0] core_a = '0;
    logic [63:0] core_b = '0;
    int          core_cnt  = 0;
    int          core_lat  = 1;
    int          lat_fixed = 0;
    bit          core_hang = 1'b0;
    int          we_cnt    = 0;
    int          we_before = 0;

    logic [3:0]  ma [16];
    logic [3:0]  mb [16];

    always #5 clk = ~clk;

    tensor_core_operand_sequencer #(.ELEM_W(4), .DIM(4), .TIMEOUT(32)) dut (
        .clock_in                              (clk),
        .reset_in                              (reset_in),
        .in_valid                              (in_valid),
        .in_ready                              (in_ready),
        .in_data                               (in_data),
        .tensor_core_input1                    (a_pk),
        .tensor_core_input2                    (b_pk),
        .tensor_core_register_file_write_enable(we),
        .tensor_core_output                    (c_pk),
        .is_done_with_calculation              (done),
        .out_valid                             (out_valid),
        .out_ready                             (out_ready),
        .out_data                              (out_data),
        .out_last                              (out_last),
        .busy                                  (busy),
        .error                                 (error)
    );

    // Behavioural stand-in for the MMA core: 4x4 product mod 16 on packed operands.
    function automatic logic [63:0] core_mma(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] c;
        int s;
        c = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++)
                    s += int'(a[(15 - (i*4 + k))*4 +: 4]) * int'(b[(15 - (k*4 + j))*4 +: 4]);
                c[(15 - (i*4 + j))*4 +: 4] = 4'(s);
            end
        end
        return c;
    endfunction

    always @(posedge clk) begin
        if (we) begin
            we_cnt    <= we_cnt + 1;
            core_done_clear();
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1 && !core_hang) begin
                c_pk <= core_mma(core_a, core_b);
                done <= 1'b1;
            end
        end
    end

    task automatic core_done_clear();
        done     <= 1'b0;
        core_a   <= a_pk;
        core_b   <= b_pk;
        core_cnt <= core_lat;
    endtask

    function automatic logic [63:0] pack(input logic [3:0] m [16]);
        logic [63:0] p;
        p = '0;
        for (int k = 0; k < 16; k++) p[(15 - k)*4 +: 4] = m[k];
        return p;
    endfunction

    // Drive 32 nibbles (A then B) with random idle cycles; ends at the START cycle.
    task automatic load_operands(input int gap_pct);
        int   acc;
        int   cyc;
        logic fire;
        acc = 0;
        cyc = 0;
        core_lat  = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 6));
        we_before = we_cnt;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready_idle got %0b want 1", in_ready);
        end
        while (acc < 32 && cyc < 3000) begin
            if (int'($urandom_range(0, 99)) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 4'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = (acc < 16) ? ma[acc] : mb[acc - 16];
            end
            fire = in_valid && in_ready;
            vectors++;
            if (we !== 1'b0) begin
                errors++;
                $display("FAIL we_during_load got %0b want 0 at accept %0d", we, acc);
            end
            @(posedge clk); #1;
            cyc++;
            if (fire) acc++;
        end
        in_valid = 1'b0;
        vectors++;
        if (acc != 32) begin
            errors++;
            $display("FAIL load_budget got %0d accepts want 32", acc);
        end
        vectors++;
        if (we !== 1'b1) begin
            errors++;
            $display("FAIL we_after_32nd got %0b want 1", we);
        end
        vectors++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_flags got in_ready=%0b busy=%0b want 0/1", in_ready, busy);
        end
        vectors++;
        if (a_pk !== pack(ma) || b_pk !== pack(mb)) begin
            errors++;
            $display("FAIL operand_pack got %h/%h want %h/%h", a_pk, b_pk, pack(ma), pack(mb));
        end
    endtask

    // From the START cycle: wait for the core, collect 16 beats with random stalls.
    task automatic drain_results(input int stall_pct);
        logic [3:0] exp_c [16];
        int         s;
        int         beat;
        int         cyc;
        logic       fire;
        logic       held;
        logic [3:0] held_d;
        logic       held_l;
        logic       want_last;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++) s += int'(ma[i*4 + k]) * int'(mb[k*4 + j]);
                exp_c[i*4 + j] = 4'(s % 16);
            end
        end
        out_ready = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (we !== 1'b0) begin
            errors++;
            $display("FAIL we_one_cycle got %0b want 0", we);
        end
        beat = 0;
        cyc  = 0;
        held = 1'b0;
        while (beat < 16 && cyc < 3000) begin
            vectors++;
            if (in_ready !== 1'b0 || we !== 1'b0) begin
                errors++;
                $display("FAIL busy_quiet got in_ready=%0b we=%0b want 0/0", in_ready, we);
            end
            if (out_valid === 1'b1) begin
                if (held) begin
                    vectors++;
                    if (out_data !== held_d || out_last !== held_l) begin
                        errors++;
                        $display("FAIL stall_stable got %h/%0b want %h/%0b", out_data, out_last, held_d, held_l);
                    end
                end
                want_last = (beat == 15);
                vectors++;
                if (out_data !== exp_c[beat]) begin
                    errors++;
                    $display("FAIL out_data[%0d] got %h want %h", beat, out_data, exp_c[beat]);
                end
                vectors++;
                if (out_last !== want_last) begin
                    errors++;
                    $display("FAIL out_last[%0d] got %0b want %0b", beat, out_last, want_last);
                end
            end
            out_ready = (int'($urandom_range(0, 99)) >= stall_pct);
            fire   = (out_valid === 1'b1) && out_ready;
            held   = (out_valid === 1'b1) && !out_ready;
            held_d = out_data;
            held_l = out_last;
            @(posedge clk); #1;
            cyc++;
            if (fire) beat++;
        end
        out_ready = 1'b0;
        vectors++;
        if (beat != 16) begin
            errors++;
            $display("FAIL drain_budget got %0d beats want 16", beat);
        end
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL back_to_load got in_ready=%0b out_valid=%0b busy=%0b want 1/0/0",
                     in_ready, out_valid, busy);
        end
        vectors++;
        if (we_cnt != we_before + 1) begin
            errors++;
            $display("FAIL we_pulses got %0d want 1", we_cnt - we_before);
        end
    endtask

    task automatic set_identity_case();
        for (int k = 0; k < 16; k++) begin
            ma[k] = ((k / 4) == (k % 4)) ? 4'd1 : 4'd0;
            mb[k] = 4'(k);
        end
    endtask

    task automatic set_fill_case(input logic [3:0] av, input logic [3:0] bv);
        for (int k = 0; k < 16; k++) begin
            ma[k] = av;
            mb[k] = bv;
        end
    endtask

    task automatic test_reset();
        reset_in  = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready_held got %0b want 0", in_ready);
        end
        reset_in = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, out_last, we, busy, error} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags got %b want 100000", {in_ready, out_valid, out_last, we, busy, error});
        end
        vectors++;
        if (a_pk !== 64'd0 || b_pk !== 64'd0) begin
            errors++;
            $display("FAIL reset_operands got %h/%h want 0/0", a_pk, b_pk);
        end
    endtask

    task automatic test_identity();
        set_identity_case();
        load_operands(0);
        drain_results(0);
    endtask

    task automatic test_ones();
        set_fill_case(4'd1, 4'd1);
        load_operands(0);
        drain_results(0);
    endtask

    task automatic test_wrap();
        set_fill_case(4'hF, 4'd1);
        load_operands(0);
        drain_results(0);
    endtask

    task automatic test_stalls();
        set_identity_case();
        load_operands(50);
        drain_results(50);
    endtask

    task automatic test_random();
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < 16; k++) begin
                ma[k] = 4'($urandom);
                mb[k] = 4'($urandom);
            end
            load_operands(30);
            drain_results(30);
        end
    endtask

    task automatic test_reset_mid_wait();
        set_identity_case();
        lat_fixed = 20;
        load_operands(0);
        lat_fixed = 0;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait_busy got busy=%0b out_valid=%0b want 1/0", busy, out_valid);
        end
        reset_in = 1'b1;
        @(posedge clk); #1;
        reset_in = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, busy, error} !== 4'b1000) begin
            errors++;
            $display("FAIL mid_wait_reset got %b want 1000", {in_ready, out_valid, busy, error});
        end
        set_fill_case(4'd1, 4'd1);
        load_operands(20);
        drain_results(20);
        vectors++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL error_after_reset got %0b want 0", error);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit saw_valid;
        set_fill_case(4'd2, 4'd3);
        core_hang = 1'b1;
        load_operands(0);
        n = 0;
        saw_valid = 1'b0;
        while (in_ready !== 1'b1 && n < 200) begin
            if (out_valid === 1'b1) saw_valid = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (n != 33) begin
            errors++;
            $display("FAIL timeout_cycles got %0d want 33", n);
        end
        vectors++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flags got error=%0b busy=%0b want 1/0", error, busy);
        end
        vectors++;
        if (saw_valid) begin
            errors++;
            $display("FAIL timeout_output got out_valid=1 want 0");
        end
        core_hang = 1'b0;
        set_identity_case();
        load_operands(0);
        drain_results(0);
        vectors++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL error_sticky got %0b want 1", error);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_ones();
        test_wrap();
        test_stalls();
        test_random();
        test_reset_mid_wait();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
